// File: rtl/prog_priority_arbiter_if.sv
// Grant and priority-table configuration bundle for prog_priority_arbiter.
// The transfer-done strobe is named release_pulse because "release" is a reserved word.
interface prog_priority_arbiter_if #(
    parameter int unsigned NUM_REQ = 16,
    parameter int unsigned PRIO_W  = 4
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic               release_pulse;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_id;
    logic               gnt_valid;

    logic               cfg_valid;
    logic               cfg_wr_rd;
    logic [IDX_W-1:0]   cfg_index;
    logic [PRIO_W-1:0]  cfg_wdata;
    logic               cfg_ready;
    logic [PRIO_W-1:0]  cfg_rdata;
    logic               cfg_rvalid;

    modport master (
        output req, release_pulse, cfg_valid, cfg_wr_rd, cfg_index, cfg_wdata,
        input  gnt, gnt_id, gnt_valid, cfg_ready, cfg_rdata, cfg_rvalid
    );

    modport slave (
        input  req, release_pulse, cfg_valid, cfg_wr_rd, cfg_index, cfg_wdata,
        output gnt, gnt_id, gnt_valid, cfg_ready, cfg_rdata, cfg_rvalid
    );
endinterface

// File: rtl/prog_priority_arbiter.sv
// Programmable-priority arbiter: highest table priority wins, ties resolved round-robin
// from rr_ptr. Grants are held until released or the request drops; the priority
// table is only writable outside the arbitration cycle.
module prog_priority_arbiter #(
    parameter int unsigned NUM_REQ = 16,
    parameter int unsigned PRIO_W  = 4
) (
    input logic                    clk,
    input logic                    rst,
    prog_priority_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StArb, StGrant} state_e;

    state_e             state_q;
    logic [PRIO_W-1:0]  prio_q [NUM_REQ];
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   gnt_id_q;
    logic               gnt_valid_q;
    logic               cfg_ready_q;
    logic [PRIO_W-1:0]  cfg_rdata_q;
    logic               cfg_rvalid_q;

    logic               win_found;
    logic [PRIO_W-1:0]  win_prio;
    logic [IDX_W-1:0]   win_id;
    logic [IDX_W-1:0]   win_next;
    logic [IDX_W-1:0]   cand;
    logic               cfg_acc;

    assign cfg_acc  = bus.cfg_valid & cfg_ready_q;
    assign win_next = (win_id == IDX_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

    // Scan requesters starting at rr_ptr; strict '>' keeps the first tied index.
    always_comb begin
        win_found = 1'b0;
        win_prio  = '0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (bus.req[cand] && (!win_found || (prio_q[cand] > win_prio))) begin
                win_found = 1'b1;
                win_prio  = prio_q[cand];
                win_id    = cand;
            end
        end
    end

    // Arbitration FSM with registered grant and cfg_ready outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|bus.req) begin
                        state_q     <= StArb;
                        cfg_ready_q <= 1'b0;
                    end else begin
                        cfg_ready_q <= 1'b1;
                    end
                end
                StArb: begin
                    cfg_ready_q <= 1'b1;
                    if (win_found) begin
                        state_q     <= StGrant;
                        gnt_q       <= NUM_REQ'(1) << win_id;
                        gnt_id_q    <= win_id;
                        gnt_valid_q <= 1'b1;
                        rr_ptr_q    <= win_next;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGrant: begin
                    if (bus.release_pulse || !bus.req[gnt_id_q]) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        // Pending requests go straight back to ARB: one dead cycle.
                        if (|(bus.req & ~gnt_q)) begin
                            state_q     <= StArb;
                            cfg_ready_q <= 1'b0;
                        end else begin
                            state_q     <= StIdle;
                            cfg_ready_q <= 1'b1;
                        end
                    end else begin
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Priority table writes and registered reads with a one-cycle rvalid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                prio_q[i] <= '0;
            end
            cfg_rdata_q  <= '0;
            cfg_rvalid_q <= 1'b0;
        end else begin
            cfg_rvalid_q <= 1'b0;
            if (cfg_acc) begin
                if (bus.cfg_wr_rd) begin
                    prio_q[bus.cfg_index] <= bus.cfg_wdata;
                end else begin
                    cfg_rdata_q  <= prio_q[bus.cfg_index];
                    cfg_rvalid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.gnt_valid  = gnt_valid_q;
    assign bus.cfg_ready  = cfg_ready_q;
    assign bus.cfg_rdata  = cfg_rdata_q;
    assign bus.cfg_rvalid = cfg_rvalid_q;
endmodule

// File: tb/tb_prog_priority_arbiter.sv
// Directed and randomized checks of prog_priority_arbiter against a behavioural model.
module tb_prog_priority_arbiter;
    localparam int unsigned NUM_REQ = 16;
    localparam int unsigned PRIO_W  = 4;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned model_prio [NUM_REQ];
    int unsigned model_rr;

    prog_priority_arbiter_if #(.NUM_REQ(NUM_REQ), .PRIO_W(PRIO_W)) bus ();

    prog_priority_arbiter #(.NUM_REQ(NUM_REQ), .PRIO_W(PRIO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Winner = highest priority; among equals, smallest upward distance from rr pointer.
    function automatic int model_winner(input logic [NUM_REQ-1:0] r);
        int best;
        int best_p;
        int best_d;
        int d;
        int n;
        n      = int'(NUM_REQ);
        best   = -1;
        best_p = -1;
        best_d = n;
        for (int i = 0; i < n; i++) begin
            if (r[i]) begin
                d = (i - int'(model_rr) + n) % n;
                if ((int'(model_prio[i]) > best_p) ||
                    ((int'(model_prio[i]) == best_p) && (d < best_d))) begin
                    best   = i;
                    best_p = int'(model_prio[i]);
                    best_d = d;
                end
            end
        end
        return best;
    endfunction

    task automatic cfg_write(input int unsigned idx, input int unsigned val);
        logic rdy;
        logic acc;
        acc = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_wr_rd = 1'b1;
        bus.cfg_index = 4'(idx);
        bus.cfg_wdata = PRIO_W'(val);
        for (int n = 0; n < 8 && !acc; n++) begin
            rdy = bus.cfg_ready;
            step();
            acc = rdy;
        end
        bus.cfg_valid = 1'b0;
        check("cfg_wr_accept", 32'(acc), 32'd1);
        model_prio[idx] = val;
    endtask

    task automatic cfg_read(input int unsigned idx, input int unsigned exp, input string tag);
        logic rdy;
        logic acc;
        acc = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_wr_rd = 1'b0;
        bus.cfg_index = 4'(idx);
        for (int n = 0; n < 8 && !acc; n++) begin
            rdy = bus.cfg_ready;
            step();
            acc = rdy;
        end
        bus.cfg_valid = 1'b0;
        check({tag, "_accept"}, 32'(acc), 32'd1);
        check({tag, "_rvalid"}, 32'(bus.cfg_rvalid), 32'd1);
        check({tag, "_rdata"}, 32'(bus.cfg_rdata), exp);
        step();
        check({tag, "_rvalid_drop"}, 32'(bus.cfg_rvalid), 32'd0);
        check({tag, "_rdata_hold"}, 32'(bus.cfg_rdata), exp);
    endtask

    initial begin
        logic [NUM_REQ-1:0] r;
        int                 w;
        int unsigned        idx;

        bus.req           = '0;
        bus.release_pulse = 1'b0;
        bus.cfg_valid     = 1'b0;
        bus.cfg_wr_rd     = 1'b0;
        bus.cfg_index     = '0;
        bus.cfg_wdata     = '0;
        model_rr          = 0;
        for (int i = 0; i < NUM_REQ; i++) model_prio[i] = 0;

        // Reset values
        rst = 1'b0;
        #12;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        check("rst_cfg_rvalid", 32'(bus.cfg_rvalid), 32'd0);
        check("rst_cfg_rdata", 32'(bus.cfg_rdata), 32'd0);
        #5 rst = 1'b1;
        #1 check("ready_low_before_edge", 32'(bus.cfg_ready), 32'd0);
        step();
        check("ready_first_edge", 32'(bus.cfg_ready), 32'd1);

        // All priorities 0, every requester active: pure round-robin 0..15,0
        bus.req = '1;
        step();
        check("rr_arb_no_gnt", 32'(bus.gnt_valid), 32'd0);
        check("rr_arb_not_ready", 32'(bus.cfg_ready), 32'd0);
        for (int j = 0; j <= 16; j++) begin
            step();
            check("rr_gnt_valid", 32'(bus.gnt_valid), 32'd1);
            check("rr_gnt_id", 32'(bus.gnt_id), 32'(j % 16));
            check("rr_gnt", 32'(bus.gnt), 32'd1 << (j % 16));
            model_rr = 32'((j % 16 + 1) % 16);
            bus.release_pulse = 1'b1;
            step();
            bus.release_pulse = 1'b0;
            check("rr_dead_cycle", 32'(bus.gnt_valid), 32'd0);
        end
        // Drop all requests while in ARB
        bus.req = '0;
        step();
        check("rr_abort_gnt", 32'(bus.gnt), 32'd0);
        check("rr_abort_ready", 32'(bus.cfg_ready), 32'd1);

        // Request vanishes during ARB: back to IDLE with no grant
        check("abort_idle_ready", 32'(bus.cfg_ready), 32'd1);
        bus.req = 16'h0010;
        step();
        check("abort_arb_ready", 32'(bus.cfg_ready), 32'd0);
        check("abort_arb_gnt", 32'(bus.gnt_valid), 32'd0);
        bus.req = '0;
        step();
        check("abort_gnt", 32'(bus.gnt), 32'd0);
        check("abort_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check("abort_ready", 32'(bus.cfg_ready), 32'd1);
        step();
        check("abort_gnt_later", 32'(bus.gnt), 32'd0);
        check("abort_ready_later", 32'(bus.cfg_ready), 32'd1);

        // Table write/read-back
        for (int i = 0; i < NUM_REQ; i++) cfg_write(32'(i), 3);
        for (int i = 0; i < NUM_REQ; i++) cfg_read(32'(i), 3, "rd3");

        // Priority beats round-robin; grant held while requested
        cfg_write(2, 9);
        cfg_write(7, 5);
        bus.req = 16'h0084;
        step();
        check("p_arb_gnt", 32'(bus.gnt), 32'd0);
        step();
        check("p_gnt", 32'(bus.gnt), 32'h0004);
        check("p_gnt_id", 32'(bus.gnt_id), 32'd2);
        check("p_model", 32'(model_winner(16'h0084)), 32'd2);
        model_rr = 3;
        for (int k = 0; k < 5; k++) begin
            step();
            check("p_hold", 32'(bus.gnt), 32'h0004);
        end
        bus.release_pulse = 1'b1;
        bus.req           = '0;
        step();
        bus.release_pulse = 1'b0;
        check("p_release", 32'(bus.gnt_valid), 32'd0);
        step();

        // No pre-emption by a higher-priority newcomer
        bus.req = 16'h0010;
        step();
        step();
        check("np_gnt_id", 32'(bus.gnt_id), 32'd4);
        model_rr = 5;
        cfg_write(5, 15);
        bus.req = 16'h0030;
        check("np_hold_after_wr", 32'(bus.gnt), 32'h0010);
        for (int k = 0; k < 3; k++) begin
            step();
            check("np_hold", 32'(bus.gnt), 32'h0010);
        end
        bus.release_pulse = 1'b1;
        bus.req           = 16'h0020;
        step();
        bus.release_pulse = 1'b0;
        check("np_dead", 32'(bus.gnt_valid), 32'd0);
        check("np_dead_ready", 32'(bus.cfg_ready), 32'd0);
        step();
        check("np_next_id", 32'(bus.gnt_id), 32'd5);
        check("np_next_gnt", 32'(bus.gnt), 32'h0020);
        model_rr = 6;
        bus.release_pulse = 1'b1;
        bus.req           = '0;
        step();
        bus.release_pulse = 1'b0;
        step();

        // Randomized priorities and request patterns against the model
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < 2; k++) cfg_write($urandom_range(0, 15), $urandom_range(0, 15));
            idx = $urandom_range(0, 15);
            cfg_read(idx, model_prio[idx], "rand_rd");
            r = NUM_REQ'($urandom);
            if (r == '0) r = 16'h0001;
            bus.req = r;
            step();
            step();
            while (r != '0) begin
                w = model_winner(r);
                check("rand_gnt_id", 32'(bus.gnt_id), 32'(w));
                check("rand_gnt", 32'(bus.gnt), 32'd1 << w);
                model_rr = 32'((w + 1) % 16);
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    step();
                    check("rand_hold", 32'(bus.gnt), 32'd1 << w);
                end
                r[w] = 1'b0;
                bus.req           = r;
                bus.release_pulse = 1'($urandom_range(0, 1));
                step();
                bus.release_pulse = 1'b0;
                check("rand_end", 32'(bus.gnt_valid), 32'd0);
                if (r != '0) step();
            end
        end

        // Asynchronous reset mid-grant with a read just returned
        bus.req = 16'h0001;
        step();
        step();
        check("ar_gnt", 32'(bus.gnt), 32'h0001);
        bus.cfg_valid = 1'b1;
        bus.cfg_wr_rd = 1'b0;
        bus.cfg_index = 4'd2;
        step();
        bus.cfg_valid = 1'b0;
        check("ar_rvalid_pre", 32'(bus.cfg_rvalid), 32'd1);
        #3 rst = 1'b0;
        #1;
        check("ar_gnt_cleared", 32'(bus.gnt), 32'd0);
        check("ar_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check("ar_rvalid", 32'(bus.cfg_rvalid), 32'd0);
        check("ar_rdata", 32'(bus.cfg_rdata), 32'd0);
        check("ar_ready", 32'(bus.cfg_ready), 32'd0);
        #2 rst = 1'b1;
        bus.req  = '0;
        model_rr = 0;
        for (int i = 0; i < NUM_REQ; i++) model_prio[i] = 0;
        step();
        check("ar_ready_rise", 32'(bus.cfg_ready), 32'd1);
        for (int i = 0; i < NUM_REQ; i++) cfg_read(32'(i), 0, "ar_rd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
